// File: rtl/axis_dac_slew_limiter.sv
// Four-channel slew-rate limiter between the SPM control stage and the DAC.
// Each channel steps its current value toward a registered target once per prescaler tick.
module axis_dac_slew_limiter (
  input  logic        a_clk,
  input  logic        reset,
  input  logic [31:0] S_AXIS1_tdata,
  input  logic [31:0] S_AXIS2_tdata,
  input  logic [31:0] S_AXIS3_tdata,
  input  logic [31:0] S_AXIS4_tdata,
  input  logic        S_AXIS1_tvalid,
  input  logic        S_AXIS2_tvalid,
  input  logic        S_AXIS3_tvalid,
  input  logic        S_AXIS4_tvalid,
  input  logic [31:0] slew_step,
  input  logic [15:0] update_period,
  input  logic        enable,
  input  logic        preload,
  output logic [31:0] M_AXIS1_tdata,
  output logic [31:0] M_AXIS2_tdata,
  output logic [31:0] M_AXIS3_tdata,
  output logic [31:0] M_AXIS4_tdata,
  output logic        M_AXIS1_tvalid,
  output logic        M_AXIS2_tvalid,
  output logic        M_AXIS3_tvalid,
  output logic        M_AXIS4_tvalid,
  output logic [3:0]  settled,
  output logic        ready
);

  logic [31:0] w_in_tdata [4];
  logic [3:0]  w_in_tvalid;
  logic [31:0] r_target   [4];
  logic [31:0] r_current  [4];
  logic [31:0] w_current_d[4];
  logic [32:0] w_diff     [4];
  logic [32:0] w_mag      [4];
  logic [3:0]  r_tvalid;
  logic [15:0] r_cnt;
  logic        w_tick;
  logic        w_jump;
  logic        w_step_en;

  always_comb begin
    w_in_tdata[0] = S_AXIS1_tdata;
    w_in_tdata[1] = S_AXIS2_tdata;
    w_in_tdata[2] = S_AXIS3_tdata;
    w_in_tdata[3] = S_AXIS4_tdata;
    w_in_tvalid   = {S_AXIS4_tvalid, S_AXIS3_tvalid, S_AXIS2_tvalid, S_AXIS1_tvalid};
  end

  // >= rather than == so lowering update_period below cnt ticks immediately
  assign w_tick = (r_cnt >= update_period);

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (w_tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_jump    = preload | (enable & (slew_step == 32'd0));
  assign w_step_en = enable & (slew_step != 32'd0) & w_tick;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_diff[n] = {r_target[n][31], r_target[n]} - {r_current[n][31], r_current[n]};
      w_mag[n]  = w_diff[n][32] ? (33'd0 - w_diff[n]) : w_diff[n];
      w_current_d[n] = r_current[n];
      if (w_jump) begin
        w_current_d[n] = r_target[n];
      end else if (w_step_en) begin
        // A partial step lands strictly between current and target, so 32-bit math cannot wrap
        if (w_mag[n] <= {1'b0, slew_step}) begin
          w_current_d[n] = r_target[n];
        end else if (w_diff[n][32]) begin
          w_current_d[n] = r_current[n] - slew_step;
        end else begin
          w_current_d[n] = r_current[n] + slew_step;
        end
      end
    end
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        r_target[n]  <= 32'd0;
        r_current[n] <= 32'd0;
      end
      r_tvalid <= 4'b0000;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_in_tvalid[n]) begin
          r_target[n] <= w_in_tdata[n];
        end
        r_current[n] <= w_current_d[n];
      end
      if (w_jump || w_step_en) begin
        r_tvalid <= 4'b1111;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      settled[n] = (r_current[n] == r_target[n]);
    end
  end

  assign ready = &settled;

  assign M_AXIS1_tdata  = r_current[0];
  assign M_AXIS2_tdata  = r_current[1];
  assign M_AXIS3_tdata  = r_current[2];
  assign M_AXIS4_tdata  = r_current[3];
  assign M_AXIS1_tvalid = r_tvalid[0];
  assign M_AXIS2_tvalid = r_tvalid[1];
  assign M_AXIS3_tvalid = r_tvalid[2];
  assign M_AXIS4_tvalid = r_tvalid[3];

endmodule

// File: tb/tb_axis_dac_slew_limiter.sv
// Directed bench for axis_dac_slew_limiter: arithmetic reference model checked every
// negedge, plus literal expectations for the hand-worked sequences.
module tb_axis_dac_slew_limiter;

  logic        a_clk = 1'b0;
  logic        reset;
  logic [31:0] s_tdata [4];
  logic [3:0]  s_tvalid;
  logic [31:0] slew_step;
  logic [15:0] update_period;
  logic        enable;
  logic        preload;
  logic [31:0] m_tdata [4];
  logic [3:0]  m_tvalid;
  logic [3:0]  settled;
  logic        ready;

  int n_vec = 0;
  int n_err = 0;

  longint      md_tgt [4] = '{0, 0, 0, 0};
  longint      md_cur [4] = '{0, 0, 0, 0};
  bit   [3:0]  md_tv  = 4'b0000;
  int unsigned md_cnt = 0;

  always #5 a_clk = ~a_clk;

  axis_dac_slew_limiter dut (
    .a_clk          (a_clk),
    .reset          (reset),
    .S_AXIS1_tdata  (s_tdata[0]),
    .S_AXIS2_tdata  (s_tdata[1]),
    .S_AXIS3_tdata  (s_tdata[2]),
    .S_AXIS4_tdata  (s_tdata[3]),
    .S_AXIS1_tvalid (s_tvalid[0]),
    .S_AXIS2_tvalid (s_tvalid[1]),
    .S_AXIS3_tvalid (s_tvalid[2]),
    .S_AXIS4_tvalid (s_tvalid[3]),
    .slew_step      (slew_step),
    .update_period  (update_period),
    .enable         (enable),
    .preload        (preload),
    .M_AXIS1_tdata  (m_tdata[0]),
    .M_AXIS2_tdata  (m_tdata[1]),
    .M_AXIS3_tdata  (m_tdata[2]),
    .M_AXIS4_tdata  (m_tdata[3]),
    .M_AXIS1_tvalid (m_tvalid[0]),
    .M_AXIS2_tvalid (m_tvalid[1]),
    .M_AXIS3_tvalid (m_tvalid[2]),
    .M_AXIS4_tvalid (m_tvalid[3]),
    .settled        (settled),
    .ready          (ready)
  );

  // Reference: plain signed arithmetic on 64-bit integers
  always @(posedge a_clk or posedge reset) begin
    if (reset) begin
      md_cnt <= 0;
      md_tv  <= 4'b0000;
      for (int n = 0; n < 4; n++) begin
        md_tgt[n] <= 0;
        md_cur[n] <= 0;
      end
    end else begin
      automatic bit tk = (md_cnt >= update_period);
      md_cnt <= tk ? 0 : md_cnt + 1;
      for (int n = 0; n < 4; n++) begin
        automatic longint d   = md_tgt[n] - md_cur[n];
        automatic longint mag = (d < 0) ? -d : d;
        automatic longint st  = longint'(slew_step);
        if (preload || (enable && slew_step == 0)) begin
          md_cur[n] <= md_tgt[n];
          md_tv[n]  <= 1'b1;
        end else if (enable && tk) begin
          md_tv[n] <= 1'b1;
          if (mag <= st) md_cur[n] <= md_tgt[n];
          else if (d > 0) md_cur[n] <= md_cur[n] + st;
          else md_cur[n] <= md_cur[n] - st;
        end
        if (s_tvalid[n]) md_tgt[n] <= longint'($signed(s_tdata[n]));
      end
    end
  end

  always @(negedge a_clk) begin
    logic [31:0] exp_d;
    logic [3:0]  exp_s;
    for (int n = 0; n < 4; n++) begin
      exp_d = md_cur[n][31:0];
      exp_s[n] = (md_cur[n] == md_tgt[n]);
      n_vec++;
      if (m_tdata[n] !== exp_d) begin
        n_err++;
        $display("FAIL model_tdata%0d t=%0t got %h want %h", n + 1, $time, m_tdata[n], exp_d);
      end
      n_vec++;
      if (m_tvalid[n] !== md_tv[n]) begin
        n_err++;
        $display("FAIL model_tvalid%0d t=%0t got %b want %b", n + 1, $time, m_tvalid[n], md_tv[n]);
      end
    end
    n_vec++;
    if (settled !== exp_s || ready !== (&exp_s)) begin
      n_err++;
      $display("FAIL model_settled t=%0t got %b/%b want %b/%b", $time, settled, ready, exp_s,
               &exp_s);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge a_clk);
    #2;
  endtask

  logic [31:0] snap [4];
  logic [31:0] prev;
  int          chg_at [$];
  bit          found;

  initial begin
    reset = 1'b1;
    for (int n = 0; n < 4; n++) s_tdata[n] = 32'd0;
    s_tvalid      = 4'b0000;
    slew_step     = 32'd0;
    update_period = 16'd0;
    enable        = 1'b0;
    preload       = 1'b0;
    step();
    for (int n = 0; n < 4; n++) chk("reset_tdata", m_tdata[n], 32'd0);
    chk("reset_tvalid", {28'd0, m_tvalid}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_settled", {28'd0, settled}, 32'hF);
    step();
    reset = 1'b0;

    // First update: step 4, every clock, ch1 target 10
    slew_step = 32'd4;
    s_tdata[0] = 32'd10;
    s_tvalid = 4'b0001;
    step();
    s_tvalid = 4'b0000;
    enable = 1'b1;
    step();
    chk("first_4", m_tdata[0], 32'd4);
    chk("first_tvalid", {31'd0, m_tvalid[0]}, 32'd1);
    step();
    chk("first_8", m_tdata[0], 32'd8);
    chk("first_unsettled", {31'd0, settled[0]}, 32'd0);
    step();
    chk("first_10", m_tdata[0], 32'd10);
    chk("first_settled", {31'd0, settled[0]}, 32'd1);

    // Negative slew; the coinciding tick still uses the old target
    s_tdata[0] = -32'sd3;
    s_tvalid = 4'b0001;
    step();
    s_tvalid = 4'b0000;
    chk("neg_hold_old", m_tdata[0], 32'd10);
    step(); chk("neg_6", m_tdata[0], 32'd6);
    step(); chk("neg_2", m_tdata[0], 32'd2);
    step(); chk("neg_m2", m_tdata[0], 32'hFFFF_FFFE);
    step(); chk("neg_m3", m_tdata[0], 32'hFFFF_FFFD);

    // Extremes without wrap
    s_tdata[0] = 32'h7FFF_FFFF;
    s_tvalid = 4'b0001;
    step();
    s_tvalid = 4'b0000;
    preload = 1'b1;
    step();
    preload = 1'b0;
    chk("ext_preload", m_tdata[0], 32'h7FFF_FFFF);
    slew_step = 32'h4000_0000;
    s_tdata[0] = 32'h8000_0000;
    s_tvalid = 4'b0001;
    step();
    s_tvalid = 4'b0000;
    step(); chk("ext_1", m_tdata[0], 32'h3FFF_FFFF);
    step(); chk("ext_2", m_tdata[0], 32'hFFFF_FFFF);
    step(); chk("ext_3", m_tdata[0], 32'hBFFF_FFFF);
    step(); chk("ext_4", m_tdata[0], 32'h8000_0000);

    // Prescaler P=3: exactly one change per 4 clocks
    update_period = 16'd3;
    slew_step = 32'd1;
    s_tdata[0] = 32'd100;
    s_tvalid = 4'b0001;
    step();
    s_tvalid = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      prev = m_tdata[0];
      step();
      if (m_tdata[0] != prev) chg_at.push_back(k);
    end
    chk("presc_count", chg_at.size(), 32'd4);
    for (int i = 1; i < chg_at.size(); i++) chk("presc_spacing", chg_at[i] - chg_at[i-1], 32'd4);

    // Lower P from 7 to 1 while cnt is 3
    update_period = 16'd7;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (md_cnt == 3) found = 1'b1;
      else step();
    end
    chk("presc_cnt3_reached", {31'd0, found}, 32'd1);
    prev = m_tdata[0];
    update_period = 16'd1;
    step();
    chk("presc_lower_tick", m_tdata[0], prev + 32'd1);
    update_period = 16'd0;

    // Enable low: outputs frozen for 20 clocks while targets move
    enable = 1'b0;
    slew_step = 32'd4;
    for (int n = 0; n < 4; n++) snap[n] = m_tdata[n];
    for (int k = 0; k < 20; k++) begin
      s_tdata[k % 4] = 32'(k * 1111 - 5000);
      s_tvalid = 4'b0001 << (k % 4);
      step();
      for (int n = 0; n < 4; n++) chk("hold", m_tdata[n], snap[n]);
    end
    s_tvalid = 4'b0000;

    // Bypass: output follows target one clock after it registers
    enable = 1'b1;
    slew_step = 32'd0;
    s_tdata[1] = 32'd1234;
    s_tvalid = 4'b0010;
    step();
    s_tvalid = 4'b0000;
    step();
    chk("bypass", m_tdata[1], 32'd1234);

    // Preload overrides enable=0
    enable = 1'b0;
    slew_step = 32'd4;
    s_tdata[2] = -32'sd77;
    s_tvalid = 4'b0100;
    step();
    s_tvalid = 4'b0000;
    preload = 1'b1;
    step();
    preload = 1'b0;
    chk("preload_dis", m_tdata[2], 32'hFFFF_FFB3);

    // Reset mid-slew on ch2
    enable = 1'b1;
    slew_step = 32'd10;
    s_tdata[1] = 32'd0;
    s_tvalid = 4'b0010;
    step();
    s_tvalid = 4'b0000;
    preload = 1'b1;
    step();
    preload = 1'b0;
    s_tdata[1] = 32'd100;
    s_tvalid = 4'b0010;
    step();
    s_tvalid = 4'b0000;
    step(); step(); step(); step();
    chk("mid_40", m_tdata[1], 32'd40);
    #1 reset = 1'b1;
    #1;
    chk("async_tdata2", m_tdata[1], 32'd0);
    chk("async_tvalid2", {31'd0, m_tvalid[1]}, 32'd0);
    chk("async_ready", {31'd0, ready}, 32'd1);
    step(); step();
    reset = 1'b0;
    step();
    chk("after_reset", m_tdata[1], 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_dac_slew_limiter.md
AXIS_DAC_SLEW_LIMITER -- requirements
Module: axis_dac_slew_limiter

Interface
REQ-001 SHALL have one clock and one reset, listed first: a_clk (input, 1, clock; all logic on the rising edge) and reset (input, 1; asynchronous, active-high).
REQ-002 SHALL have inputs S_AXIS1..4_tdata (input, 32 each), the signed setpoint targets from the SPM control stage.
REQ-003 SHALL have inputs S_AXIS1..4_tvalid (input, 1 each), the target-valid strobes.
REQ-004 SHALL have input slew_step (input, 32, unsigned), the maximum change per update tick; 0 selects bypass.
REQ-005 SHALL have input update_period (input, 16, unsigned); one update tick occurs every update_period+1 clocks.
REQ-006 SHALL have input enable (input, 1); 0 freezes the outputs.
REQ-007 SHALL have input preload (input, 1); 1 jumps every current value to its target.
REQ-008 SHALL have outputs M_AXIS1..4_tdata (output, 32 each), the slew-limited signed values sent to the DAC stage.
REQ-009 SHALL have outputs M_AXIS1..4_tvalid (output, 1 each), the output-valid strobes.
REQ-010 SHALL have output settled (output, 4); bit n-1 is 1 when channel n's current value equals its target.
REQ-011 SHALL have output ready (output, 1), equal to the AND of all four settled bits.

Function
REQ-012 SHALL register target[n] from S_AXISn_tdata on every clock where S_AXISn_tvalid=1, and hold it otherwise.
REQ-013 SHALL run a 16-bit prescaler cnt: tick=1 when cnt>=update_period, then cnt<=0; otherwise cnt<=cnt+1.
REQ-014 SHALL tick every clock when update_period=0.
REQ-015 SHALL, when update_period is lowered below the current cnt, tick on the next clock and restart cnt at 0.
REQ-016 SHALL, on a tick with enable=1 and slew_step!=0, compute per channel diff = target - current in 33-bit signed arithmetic (registered target, i.e. pre-edge value).
REQ-017 SHALL set current<=target when |diff|<=slew_step; otherwise SHALL set current<=current+slew_step when diff>0, or current<=current-slew_step when diff<0, using 33-bit intermediates.
REQ-018 SHALL never wrap the output through the signed 32-bit extremes, because each step moves toward a representable target.
REQ-019 SHALL, when slew_step=0 and enable=1, set current<=target on every clock, independent of tick.
REQ-020 SHALL, when enable=0, hold current, keep cnt running, and leave tvalid unchanged.
REQ-021 SHALL, when preload=1, set current<=target for all channels on that clock, overriding enable and tick; preload SHALL NOT reset cnt.
REQ-022 SHALL drive M_AXISn_tdata directly from the current[n] register; latency from a target edge to the first output change is 1 clock plus the wait for the next tick.
REQ-023 SHALL set M_AXISn_tvalid to 1 at the first clock edge where current is updated by a tick, bypass or preload, and SHALL keep it at 1 until reset.
REQ-024 SHALL compute settled and ready combinationally from registered current and target.
REQ-025 SHALL, when a target update and a tick coincide, step toward the old target; the new target governs from the next tick.

Reset
REQ-026 SHALL, while reset=1, asynchronously force: current=0, target=0, cnt=0, M_AXISn_tdata=0, M_AXISn_tvalid=0; settled=4'b1111 and ready=1 as a consequence.
REQ-027 SHALL, on reset mid-slew, abandon the slew, require no drain, and start from 0 on the first clock after release.

Verification
REQ-028 SHALL cover reset and first update: with reset asserted, all tdata=0, tvalid=0, ready=1; after release with step=4, P=0 and ch1 target 10, ch1 outputs 4, 8, 10 on consecutive clocks, tvalid1 goes high with the first step, and settled[0] is 1 from the third update.
REQ-029 SHALL cover negative slew: from current 10 with target -3 and step 4, outputs are 6, 2, -2, -3.
REQ-030 SHALL cover the extremes: preload to 0x7FFFFFFF, then target 0x80000000 with step 0x40000000 gives 0x3FFFFFFF, 0xFFFFFFFF, 0xBFFFFFFF, 0x80000000 with no wrap.
REQ-031 SHALL cover the prescaler: with P=3, the output changes exactly every 4 clocks; lowering P to 1 while cnt=3 gives a tick on the next clock.
REQ-032 SHALL cover enable, bypass and preload: enable=0 holds the outputs for 20 clocks while targets change; step=0 makes the output follow the target with 1-clock latency; preload=1 with enable=0 still jumps to the target.
REQ-033 SHALL cover reset mid-slew: asserting reset when ch2 is at 40 toward 100 clears tdata2 to 0 and tvalid2 to 0 immediately, without waiting for a clock edge.
